// File: rtl/pcs_tx_code_group_sequencer.sv
// 1000BASE-X PCS transmit code-group sequencer.
// Expands the ordered set chosen by the transmit ordered-set FSM into one
// pre-8b/10b code-group per clock. It drives tx_even and tx_oset_indicate
// back to that FSM, which paces it.
// /I/ and /C/ must start on an even slot. A misaligned request is replaced
// by a single /V/ and reported with a one-cycle align_err pulse.
module pcs_tx_code_group_sequencer #(
    parameter int         CFG_W = 16,
    parameter logic [7:0] K28_5 = 8'hBC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       tx_o_set,
    input  logic [7:0]       txd,
    input  logic [CFG_W-1:0] tx_config_reg,
    input  logic             rd_positive,
    output logic [7:0]       tx_cg,
    output logic             tx_is_k,
    output logic             tx_even,
    output logic             tx_oset_indicate,
    output logic             align_err
);

    // Ordered-set selector encoding
    localparam logic [2:0] OS_C = 3'd0;
    localparam logic [2:0] OS_I = 3'd1;
    localparam logic [2:0] OS_S = 3'd2;
    localparam logic [2:0] OS_V = 3'd3;
    localparam logic [2:0] OS_T = 3'd4;
    localparam logic [2:0] OS_R = 3'd5;
    localparam logic [2:0] OS_D = 3'd6;

    // Phase states: which code-group of a multi-group set is emitted next
    localparam logic [2:0] SINGLE = 3'd0;
    localparam logic [2:0] IDLE_2 = 3'd1;
    localparam logic [2:0] CFG_1  = 3'd2;
    localparam logic [2:0] CFG_2  = 3'd3;
    localparam logic [2:0] CFG_3  = 3'd4;

    // Fixed code-group values
    localparam logic [7:0] CG_S    = 8'hFB;
    localparam logic [7:0] CG_T    = 8'hFD;
    localparam logic [7:0] CG_R    = 8'hF7;
    localparam logic [7:0] CG_V    = 8'hFE;
    localparam logic [7:0] CG_I1   = 8'hC5;
    localparam logic [7:0] CG_I2   = 8'h50;
    localparam logic [7:0] CG_C1   = 8'hB5;
    localparam logic [7:0] CG_C2   = 8'h42;

    logic [2:0]       state, state_n;
    logic             c_sel, c_sel_n;
    logic             rd_lat, rd_lat_n;
    logic [CFG_W-1:0] cfg_lat, cfg_lat_n;
    logic [15:0]      cfg_word;
    logic [7:0]       cg_n;
    logic             k_n;
    logic             ind_n;
    logic             err_n;

    assign cfg_word = 16'(cfg_lat);

    // Next code-group, phase and latched set parameters
    always_comb begin
        state_n   = state;
        c_sel_n   = c_sel;
        rd_lat_n  = rd_lat;
        cfg_lat_n = cfg_lat;
        cg_n      = CG_V;
        k_n       = 1'b1;
        ind_n     = 1'b1;
        err_n     = 1'b0;
        case (state)
            SINGLE: begin
                case (tx_o_set)
                    OS_C: begin
                        if (tx_even) begin
                            err_n = 1'b1;
                        end else begin
                            cg_n      = K28_5;
                            ind_n     = 1'b0;
                            cfg_lat_n = tx_config_reg;
                            state_n   = CFG_1;
                        end
                    end
                    OS_I: begin
                        if (tx_even) begin
                            err_n = 1'b1;
                        end else begin
                            cg_n     = K28_5;
                            ind_n    = 1'b0;
                            rd_lat_n = rd_positive;
                            c_sel_n  = 1'b0;
                            state_n  = IDLE_2;
                        end
                    end
                    OS_S: begin
                        cg_n    = CG_S;
                        c_sel_n = 1'b0;
                    end
                    OS_T: begin
                        cg_n    = CG_T;
                        c_sel_n = 1'b0;
                    end
                    OS_R: begin
                        cg_n    = CG_R;
                        c_sel_n = 1'b0;
                    end
                    OS_D: begin
                        cg_n    = txd;
                        k_n     = 1'b0;
                        c_sel_n = 1'b0;
                    end
                    default: begin
                        cg_n    = CG_V;
                        c_sel_n = 1'b0;
                    end
                endcase
            end
            IDLE_2: begin
                cg_n    = rd_lat ? CG_I1 : CG_I2;
                k_n     = 1'b0;
                state_n = SINGLE;
            end
            CFG_1: begin
                cg_n    = c_sel ? CG_C2 : CG_C1;
                k_n     = 1'b0;
                ind_n   = 1'b0;
                state_n = CFG_2;
            end
            CFG_2: begin
                cg_n    = cfg_word[7:0];
                k_n     = 1'b0;
                ind_n   = 1'b0;
                state_n = CFG_3;
            end
            CFG_3: begin
                cg_n    = cfg_word[15:8];
                k_n     = 1'b0;
                c_sel_n = ~c_sel;
                state_n = SINGLE;
            end
            default: begin
                state_n = SINGLE;
            end
        endcase
    end

    // Register outputs and phase; tx_even alternates every code-group
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= SINGLE;
            c_sel            <= 1'b0;
            rd_lat           <= 1'b0;
            cfg_lat          <= '0;
            tx_cg            <= K28_5;
            tx_is_k          <= 1'b1;
            tx_even          <= 1'b0;
            tx_oset_indicate <= 1'b1;
            align_err        <= 1'b0;
        end else begin
            state            <= state_n;
            c_sel            <= c_sel_n;
            rd_lat           <= rd_lat_n;
            cfg_lat          <= cfg_lat_n;
            tx_cg            <= cg_n;
            tx_is_k          <= k_n;
            tx_even          <= ~tx_even;
            tx_oset_indicate <= ind_n;
            align_err        <= err_n;
        end
    end

    // OS_V is covered by the default branch above (reserved also maps to /V/)
    logic unused_os_v;
    assign unused_os_v = ^OS_V;

endmodule

// File: tb/tb_pcs_tx_code_group_sequencer.sv
// Testbench for pcs_tx_code_group_sequencer: directed vector table,
// a hand-written mid-set sequence, then randomized traffic checked
// against a queue-based reference model.
module tb_pcs_tx_code_group_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  tx_o_set = 3'd1;
    logic [7:0]  txd = 8'h00;
    logic [15:0] tx_config_reg = 16'h0000;
    logic        rd_positive = 1'b1;
    logic [7:0]  tx_cg;
    logic        tx_is_k;
    logic        tx_even;
    logic        tx_oset_indicate;
    logic        align_err;

    int pass_count = 0;
    int check_count = 0;

    // Free-running code-group clock
    always #5 clk = ~clk;

    pcs_tx_code_group_sequencer #(.CFG_W(16), .K28_5(8'hBC)) dut (
        .clk              (clk),
        .reset            (reset),
        .tx_o_set         (tx_o_set),
        .txd              (txd),
        .tx_config_reg    (tx_config_reg),
        .rd_positive      (rd_positive),
        .tx_cg            (tx_cg),
        .tx_is_k          (tx_is_k),
        .tx_even          (tx_even),
        .tx_oset_indicate (tx_oset_indicate),
        .align_err        (align_err)
    );

    typedef struct {
        logic        rst;
        logic [2:0]  oset;
        logic [7:0]  data;
        logic [15:0] cfg;
        logic        rd;
        logic [7:0]  cg;
        logic        k;
        logic        even;
        logic        ind;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [2:0] os, input logic [7:0] d,
                                input logic [15:0] c, input logic rdp, input logic [7:0] cg,
                                input logic k, input logic ev, input logic ind, input logic err);
        vec_t v;
        v.rst = r; v.oset = os; v.data = d; v.cfg = c; v.rd = rdp;
        v.cg = cg; v.k = k; v.even = ev; v.ind = ind; v.err = err;
        return v;
    endfunction

    // Reference model: each sampled set is expanded into a queue of
    // {K, code-group} entries and one entry is played out per clock.
    logic [8:0] mq[$];
    int         m_pos = 0;
    logic       m_csel = 1'b0;
    logic [7:0] m_cg = 8'hBC;
    logic       m_k = 1'b1;
    logic       m_even = 1'b0;
    logic       m_ind = 1'b1;
    logic       m_err = 1'b0;
    logic [8:0] m_item;
    logic       m_slot_even;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_pos = 0; m_csel = 1'b0;
            m_cg = 8'hBC; m_k = 1'b1; m_even = 1'b0; m_ind = 1'b1; m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            m_slot_even = (m_pos % 2 == 0);
            if (mq.size() == 0) begin
                if ((tx_o_set == 3'd0 || tx_o_set == 3'd1) && !m_slot_even) begin
                    mq.push_back({1'b1, 8'hFE});
                    m_err = 1'b1;
                end else begin
                    case (tx_o_set)
                        3'd0: begin
                            mq.push_back({1'b1, 8'hBC});
                            mq.push_back({1'b0, m_csel ? 8'h42 : 8'hB5});
                            mq.push_back({1'b0, tx_config_reg[7:0]});
                            mq.push_back({1'b0, tx_config_reg[15:8]});
                            m_csel = ~m_csel;
                        end
                        3'd1: begin
                            mq.push_back({1'b1, 8'hBC});
                            mq.push_back({1'b0, rd_positive ? 8'hC5 : 8'h50});
                            m_csel = 1'b0;
                        end
                        3'd2: begin mq.push_back({1'b1, 8'hFB}); m_csel = 1'b0; end
                        3'd4: begin mq.push_back({1'b1, 8'hFD}); m_csel = 1'b0; end
                        3'd5: begin mq.push_back({1'b1, 8'hF7}); m_csel = 1'b0; end
                        3'd6: begin mq.push_back({1'b0, txd});   m_csel = 1'b0; end
                        default: begin mq.push_back({1'b1, 8'hFE}); m_csel = 1'b0; end
                    endcase
                end
            end
            m_item = mq.pop_front();
            m_k    = m_item[8];
            m_cg   = m_item[7:0];
            m_ind  = (mq.size() == 0);
            m_even = m_slot_even;
            m_pos++;
        end
    end

    // Drive inputs away from the sampling edge
    task automatic applyStimulus(input logic r, input logic [2:0] os, input logic [7:0] d,
                                 input logic [15:0] c, input logic rdp);
        @(negedge clk);
        reset = r; tx_o_set = os; txd = d; tx_config_reg = c; rd_positive = rdp;
    endtask

    // Compare DUT outputs just after the edge against explicit values
    task automatic checkOutput(input string name, input logic [7:0] cg, input logic k,
                               input logic ev, input logic ind, input logic err);
        logic [11:0] got, exp;
        @(posedge clk);
        #1;
        got = {tx_cg, tx_is_k, tx_even, tx_oset_indicate, align_err};
        exp = {cg, k, ev, ind, err};
        check_count++;
        if (got === exp) pass_count++;
        else $display("[TB] FAIL %s: got cg=%h k=%b even=%b ind=%b err=%b, expected cg=%h k=%b even=%b ind=%b err=%b",
                      name, tx_cg, tx_is_k, tx_even, tx_oset_indicate, align_err, cg, k, ev, ind, err);
    endtask

    // Compare DUT outputs just after the edge against the reference model
    task automatic checkModel(input string name);
        logic [11:0] got, exp;
        @(posedge clk);
        #1;
        got = {tx_cg, tx_is_k, tx_even, tx_oset_indicate, align_err};
        exp = {m_cg, m_k, m_even, m_ind, m_err};
        check_count++;
        if (got === exp) pass_count++;
        else $display("[TB] FAIL %s: got cg=%h k=%b even=%b ind=%b err=%b, expected cg=%h k=%b even=%b ind=%b err=%b",
                      name, tx_cg, tx_is_k, tx_even, tx_oset_indicate, align_err, m_cg, m_k, m_even, m_ind, m_err);
    endtask

    initial begin
        // reset, /I/ with both disparities
        vecs.push_back(mk(1, 1, 8'h00, 16'h0000, 1, 8'hBC, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 8'h00, 16'h0000, 1, 8'hBC, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 16'h0000, 0, 8'hC5, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 8'h00, 16'h0000, 0, 8'hBC, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 8'h50, 0, 0, 1, 0));
        // /C/ C1 then C2, config changed mid-set
        vecs.push_back(mk(0, 0, 8'h00, 16'h01A0, 0, 8'hBC, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'hFFFF, 0, 8'hB5, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'hFFFF, 0, 8'hA0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'hFFFF, 0, 8'h01, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h01A0, 0, 8'hBC, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h01A0, 0, 8'h42, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h01A0, 0, 8'hA0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h01A0, 0, 8'h01, 0, 0, 1, 0));
        // single-group sets
        vecs.push_back(mk(0, 2, 8'h00, 16'h01A0, 0, 8'hFB, 1, 1, 1, 0));
        vecs.push_back(mk(0, 6, 8'h55, 16'h01A0, 0, 8'h55, 0, 0, 1, 0));
        vecs.push_back(mk(0, 6, 8'hAA, 16'h01A0, 0, 8'hAA, 0, 1, 1, 0));
        vecs.push_back(mk(0, 4, 8'h00, 16'h01A0, 0, 8'hFD, 1, 0, 1, 0));
        vecs.push_back(mk(0, 5, 8'h00, 16'h01A0, 0, 8'hF7, 1, 1, 1, 0));
        // misaligned /I/ then realigned /I/
        vecs.push_back(mk(0, 1, 8'h00, 16'h01A0, 1, 8'hFE, 1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 8'h00, 16'h01A0, 1, 8'hBC, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h1234, 1, 8'h50 ^ 8'h95, 0, 0, 1, 0));
        // /C/ with selector toggling mid-set, then /I/, then /C/ restarts at C1
        vecs.push_back(mk(0, 0, 8'h00, 16'h1234, 0, 8'hBC, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 16'h0000, 0, 8'hB5, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3, 8'h00, 16'h0000, 0, 8'h34, 0, 1, 0, 0));
        vecs.push_back(mk(0, 2, 8'h00, 16'h0000, 0, 8'h12, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 8'h00, 16'h0000, 0, 8'hBC, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h1234, 0, 8'h50, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h1234, 0, 8'hBC, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h1234, 0, 8'hB5, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h1234, 0, 8'h34, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h1234, 0, 8'h12, 0, 0, 1, 0));
        // misaligned /C/, reserved and /V/ selectors
        vecs.push_back(mk(0, 2, 8'h00, 16'h1234, 0, 8'hFB, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h1234, 0, 8'hFE, 1, 0, 1, 1));
        vecs.push_back(mk(0, 7, 8'h00, 16'h1234, 0, 8'hFE, 1, 1, 1, 0));
        vecs.push_back(mk(0, 3, 8'h00, 16'h1234, 0, 8'hFE, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h1234, 0, 8'hBC, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h1234, 0, 8'hB5, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h1234, 0, 8'h34, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h1234, 0, 8'h12, 0, 0, 1, 0));
        // reset during /C/ group 2, next set starts even with C1
        vecs.push_back(mk(0, 0, 8'h00, 16'h1234, 0, 8'hBC, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h1234, 0, 8'h42, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 8'h00, 16'h1234, 0, 8'hBC, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 8'h00, 16'h1234, 1, 8'hBC, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h1234, 1, 8'hC5, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h1234, 0, 8'hBC, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h1234, 0, 8'hB5, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h1234, 0, 8'h34, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h1234, 0, 8'h12, 0, 0, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].oset, vecs[i].data, vecs[i].cfg, vecs[i].rd);
            checkOutput($sformatf("vec%0d", i), vecs[i].cg, vecs[i].k, vecs[i].even,
                        vecs[i].ind, vecs[i].err);
        end

        // Hand-written: config word churns every cycle of a /C/, then reset mid-/I/
        applyStimulus(1, 3'd0, 8'h00, 16'h0000, 0);
        checkOutput("seq_reset", 8'hBC, 1, 0, 1, 0);
        applyStimulus(0, 3'd0, 8'h00, 16'hBEEF, 0);
        checkOutput("seq_c_g1", 8'hBC, 1, 1, 0, 0);
        applyStimulus(0, 3'd6, 8'h11, 16'h1111, 1);
        checkOutput("seq_c_g2", 8'hB5, 0, 0, 0, 0);
        applyStimulus(0, 3'd1, 8'h22, 16'h2222, 1);
        checkOutput("seq_c_g3", 8'hEF, 0, 1, 0, 0);
        applyStimulus(0, 3'd2, 8'h33, 16'h3333, 1);
        checkOutput("seq_c_g4", 8'hBE, 0, 0, 1, 0);
        applyStimulus(0, 3'd1, 8'h00, 16'h3333, 1);
        checkOutput("seq_i_g1", 8'hBC, 1, 1, 0, 0);
        applyStimulus(1, 3'd1, 8'h00, 16'h3333, 1);
        checkOutput("seq_i_abort", 8'hBC, 1, 0, 1, 0);
        applyStimulus(0, 3'd6, 8'h7E, 16'h3333, 1);
        checkOutput("seq_d_after", 8'h7E, 0, 1, 1, 0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            logic [3:0] pick;
            logic [2:0] os;
            pick = 4'($urandom_range(0, 11));
            os = (pick > 4'd7) ? {2'b00, pick[0]} : pick[2:0];
            applyStimulus(($urandom_range(0, 60) == 0), os, 8'($urandom),
                          16'($urandom), 1'($urandom));
            checkModel($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/pcs_tx_code_group_sequencer.md
Name: pcs_tx_code_group_sequencer

Overview:
- Sequences the 1000BASE-X PCS transmit path, one code-group per clock.
- Consumes the ordered-set selection `tx_o_set` from the transmit ordered-set FSM and expands each set into its pre-8b/10b code-groups (8-bit value plus K flag).
- Generates `tx_even` and `tx_oset_indicate` back to that FSM, so this block paces it.
- Sits between the ordered-set FSM and the 8b/10b encoder.

Parameters:
- CFG_W, 16, width of the auto-negotiation config register carried in /C/.
- K28_5, 8'hBC, comma code-group used in /C/ and /I/.

Ports:
- clk  in  1  PCS transmit clock, one code-group per cycle.
- reset  in  1  synchronous, active-high.
- tx_o_set  in  3  ordered-set select: 0=/C/, 1=/I/, 2=/S/, 3=/V/, 4=/T/, 5=/R/, 6=/D/, 7=reserved.
- txd  in  8  GMII data, used for /D/.
- tx_config_reg  in  CFG_W  config word sent in /C/.
- rd_positive  in  1  encoder running disparity is positive, valid each cycle.
- tx_cg  out  8  code-group to the encoder.
- tx_is_k  out  1  tx_cg is a K code-group.
- tx_even  out  1  tx_cg occupies an even position.
- tx_oset_indicate  out  1  tx_cg is the last code-group of the current set.
- align_err  out  1  one-cycle pulse on a misaligned multi-group request.

Behaviour:
- All outputs are registered.
- Reset values: tx_cg=8'hBC, tx_is_k=1, tx_even=0, tx_oset_indicate=1, align_err=0. Internal phase=0, c_sel=C1.
- Sampling rule: on each rising edge where tx_oset_indicate=1, sample tx_o_set, txd and rd_positive. The first code-group of the selected set appears on tx_cg in the next cycle, so latency is 1 clock.
- No sampling mid-set: tx_o_set changes while tx_oset_indicate=0 are ignored.
- tx_even toggles every cycle unconditionally. The first post-reset code-group is even.
- Single-group sets (code-group, K flag), each with tx_oset_indicate=1 every cycle:
  - /S/: FB, K=1.
  - /T/: FD, K=1.
  - /R/: F7, K=1.
  - /V/: FE, K=1.
  - /D/: txd, K=0.
  - reserved: treated as /V/.
- /I/ (two groups): BC then D5.6=C5 (I1) if sampled rd_positive=1; otherwise BC then D16.2=50 (I2). The first group is K, the second is D. tx_oset_indicate is high on the second group only.
- /C/ (four groups): BC, then D21.5=B5 for C1 or D2.2=42 for C2, then cfg[7:0], then cfg[15:8].
  - tx_config_reg is latched at the sampling edge, so mid-set changes do not tear the word.
  - tx_oset_indicate is high on the 4th group.
  - c_sel toggles after each completed /C/.
  - Sampling any non-/C/ set forces c_sel back to C1.
- Alignment: /I/ and /C/ must start on an even position. If one is sampled when the next slot is odd, emit a single /V/ (FE, K=1, indicate=1) instead and pulse align_err. c_sel is unchanged.
- FSM states: SINGLE, IDLE_2, CFG_1, CFG_2, CFG_3. The phase counter returns to SINGLE-ready on the indicate cycle.
- Reset mid-set aborts immediately to reset values. The next set starts even.

Test Plan:
- Release reset with tx_o_set=1, rd_positive=1 → cycles 1..2 give BC(K), C5(D); indicate=0 then 1; tx_even=1 then 0. Repeat with rd_positive=0 → BC, 50.
- Hold tx_o_set=0, tx_config_reg=16'h01A0 → BC,B5,A0,01 then BC,42,A0,01 repeating; indicate high every 4th cycle. Change cfg mid-set → the current set is unaffected.
- Sequence /S/, /D/ with txd=55,AA, then /T/, /R/ → FB, 55, AA, FD, F7; indicate=1 on every cycle.
- Request /I/ when the next slot is odd (after one /S/) → FE(K), align_err=1 for one cycle, then BC/C5 on even alignment.
- Toggle tx_o_set during /C/ groups 2–3 → ignored until indicate; after a /C/→/I/→/C/ sequence the next /C/ starts with C1 (B5).
- Assert reset at /C/ group 2 → next cycle outputs BC, K=1, indicate=1, tx_even=0; the next sampled set starts even.
